// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt sequencer.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRAP    = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } irq_state_t;

  localparam logic [31:0] MCAUSE_INT_BIT = 32'h8000_0000;
  localparam int          IRQ_CAUSE_BASE = 16;
  localparam int          MIE_IRQ_LSB    = 16;

  // Interrupt cause: bit 31 set, 5-bit code (base + source index) zero-extended.
  function automatic logic [31:0] cause_code(input logic [3:0] id);
    logic [4:0] code;
    code = 5'(IRQ_CAUSE_BASE) + {1'b0, id};
    return MCAUSE_INT_BIT | {27'd0, code};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the interrupt candidate vector.
module irq_prio_enc #(
  parameter int N_IRQ = 16
) (
  input  logic [N_IRQ-1:0] req_i,
  output logic             valid_o,
  output logic [3:0]       idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 4'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt sequencer: edge-latches requests, masks with mie, raises one trap at a
// time towards csr_controller and tracks the handler until mret.
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [31:0]      mie_i,
  input  logic             stall_i,
  input  logic             mret_i,
  output logic             trap_o,
  output logic [31:0]      mcause_o,
  output logic             busy_o,
  output logic             irq_ret_o,
  output logic [N_IRQ-1:0] irq_ack_o
);

  irq_state_t       state_q, state_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] req_q, req_d;
  logic [3:0]       id_q, id_d;
  logic [31:0]      mcause_q, mcause_d;

  logic [N_IRQ-1:0] req_edge;
  logic [N_IRQ-1:0] mie_irq;
  logic [N_IRQ-1:0] cand;
  logic [N_IRQ-1:0] id_onehot;
  logic             cand_vld;
  logic [3:0]       cand_idx;
  logic             clr_sel;

  assign req_edge = irq_req_i & ~req_q;
  assign mie_irq  = N_IRQ'(mie_i >> MIE_IRQ_LSB);
  assign cand     = pending_q & mie_irq;
  assign mcause_o = mcause_q;

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
    .req_i   (cand),
    .valid_o (cand_vld),
    .idx_o   (cand_idx)
  );

  always_comb begin
    for (int k = 0; k < N_IRQ; k++) id_onehot[k] = (id_q == 4'(k));
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    mcause_d  = mcause_q;
    clr_sel   = 1'b0;
    trap_o    = 1'b0;
    busy_o    = 1'b0;
    irq_ret_o = 1'b0;
    irq_ack_o = '0;
    req_d     = irq_req_i;
    case (state_q)
      IDLE: begin
        // mcause is loaded on entry so it is already valid while trap_o is high.
        if (cand_vld && !stall_i) begin
          id_d     = cand_idx;
          mcause_d = cause_code(cand_idx);
          state_d  = TRAP;
        end
      end
      TRAP: begin
        trap_o  = 1'b1;
        clr_sel = 1'b1;
        state_d = HANDLER;
      end
      HANDLER: begin
        busy_o = 1'b1;
        if (mret_i) state_d = RETURN;
      end
      RETURN: begin
        irq_ret_o = 1'b1;
        irq_ack_o = id_onehot;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new edge on the serviced line in the TRAP cycle keeps it pending.
    pending_d = (pending_q & ~(clr_sel ? id_onehot : '0)) | req_edge;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      req_q     <= '0;
      id_q      <= '0;
      mcause_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      id_q      <= id_d;
      mcause_q  <= mcause_d;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed vector table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_irq_controller;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  irq = '0;
  logic [31:0]   mie = '0;
  logic          stall = 1'b0;
  logic          mret = 1'b0;
  logic          trap_o;
  logic [31:0]   mcause_o;
  logic          busy_o;
  logic          ret_o;
  logic [N-1:0]  ack_o;

  int vectors = 0;
  int errors  = 0;

  irq_controller #(.N_IRQ(N)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .irq_req_i (irq),
    .mie_i     (mie),
    .stall_i   (stall),
    .mret_i    (mret),
    .trap_o    (trap_o),
    .mcause_o  (mcause_o),
    .busy_o    (busy_o),
    .irq_ret_o (ret_o),
    .irq_ack_o (ack_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] irq;
    logic [31:0] mie;
    logic        stall;
    logic        mret;
    logic        trap;
    logic [31:0] mcause;
    logic        busy;
    logic        ret;
    logic [15:0] ack;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic [15:0] i, logic [31:0] m, logic s, logic mr,
                             logic t, logic [31:0] c, logic b, logic rt, logic [15:0] a);
    vec_t x;
    x.rst = r; x.irq = i; x.mie = m; x.stall = s; x.mret = mr;
    x.trap = t; x.mcause = c; x.busy = b; x.ret = rt; x.ack = a;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] i, input logic [31:0] m,
                      input logic s, input logic mr);
    rst = r; irq = i; mie = m; stall = s; mret = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic t, input logic [31:0] c,
                         input logic b, input logic rt, input logic [15:0] a);
    chk({tag, ".trap"}, {31'd0, trap_o}, {31'd0, t});
    chk({tag, ".mcause"}, mcause_o, c);
    chk({tag, ".busy"}, {31'd0, busy_o}, {31'd0, b});
    chk({tag, ".ret"}, {31'd0, ret_o}, {31'd0, rt});
    chk({tag, ".ack"}, {16'd0, ack_o}, {16'd0, a});
  endtask

  // Behavioural reference: pending set of sources plus which phase of service
  // the single in-flight interrupt is in.
  bit          m_prev[N];
  bit          m_pend[N];
  bit          m_trap, m_hand, m_ret;
  int          m_id;
  logic [31:0] m_cause;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin m_prev[k] = 0; m_pend[k] = 0; end
    m_trap = 0; m_hand = 0; m_ret = 0; m_id = 0; m_cause = 0;
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] i, input logic [31:0] m,
                            input logic s, input logic mr);
    bit rose[N];
    int pick;
    if (!r) begin
      model_reset();
      return;
    end
    for (int k = 0; k < N; k++) rose[k] = i[k] && !m_prev[k];
    if (m_trap) begin
      m_pend[m_id] = 0;
      m_trap = 0; m_hand = 1;
    end else if (m_hand) begin
      if (mr) begin m_hand = 0; m_ret = 1; end
    end else if (m_ret) begin
      m_ret = 0;
    end else begin
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && m_pend[k] && m[16 + k]) pick = k;
      if (pick >= 0 && !s) begin
        m_id    = pick;
        m_cause = 32'h8000_0000 + 32'(16 + pick);
        m_trap  = 1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (rose[k]) m_pend[k] = 1;
      m_prev[k] = i[k];
    end
  endtask

  localparam logic [31:0] M3  = 32'h0008_0000;
  localparam logic [31:0] M25 = 32'h0024_0000;
  localparam logic [31:0] M7  = 32'h0080_0000;
  localparam logic [31:0] C10 = 32'h8000_0010;
  localparam logic [31:0] C11 = 32'h8000_0011;
  localparam logic [31:0] C12 = 32'h8000_0012;
  localparam logic [31:0] C13 = 32'h8000_0013;
  localparam logic [31:0] C15 = 32'h8000_0015;
  localparam logic [31:0] C17 = 32'h8000_0017;

  initial begin
    bit seen;
    logic [N-1:0] rirq;
    logic [31:0]  rmie;
    logic rs, rst_r, rm;

    // Directed vectors: inputs for the cycle, outputs expected after the edge.
    tbl.push_back(v(0, 16'h0000, 32'h0, 0, 0, 0, 32'h0, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0008, M3, 0, 0, 0, 32'h0, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0008, M3, 0, 0, 1, C13, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0008, M3, 0, 0, 0, C13, 1, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0008, M3, 0, 0, 0, C13, 1, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0008, M3, 0, 1, 0, C13, 0, 1, 16'h0008));
    tbl.push_back(v(1, 16'h0008, M3, 0, 0, 0, C13, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0000, M25, 0, 0, 0, C13, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0024, M25, 0, 0, 0, C13, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0024, M25, 0, 0, 1, C12, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0024, M25, 0, 0, 0, C12, 1, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0024, M25, 0, 1, 0, C12, 0, 1, 16'h0004));
    tbl.push_back(v(1, 16'h0024, M25, 0, 0, 0, C12, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0024, M25, 0, 0, 1, C15, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0024, M25, 0, 0, 0, C15, 1, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0024, M25, 0, 1, 0, C15, 0, 1, 16'h0020));
    tbl.push_back(v(1, 16'h0024, M25, 0, 0, 0, C15, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0024, M25, 0, 1, 0, C15, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 0, 0, C15, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 0, 1, C17, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0000, M7, 0, 0, 0, C17, 1, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 0, 0, C17, 1, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 0, 0, C17, 1, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 1, 0, C17, 0, 1, 16'h0080));
    tbl.push_back(v(1, 16'h0080, M7, 0, 0, 0, C17, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 0, 1, C17, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 0, 0, C17, 1, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 1, 0, C17, 0, 1, 16'h0080));
    tbl.push_back(v(1, 16'h0000, M7, 0, 0, 0, C17, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 0, 0, C17, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0000, M7, 0, 0, 1, C17, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 0, 0, C17, 1, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 1, 0, C17, 0, 1, 16'h0080));
    tbl.push_back(v(1, 16'h0080, M7, 0, 0, 0, C17, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 0, 1, C17, 0, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 0, 0, C17, 1, 0, 16'h0000));
    tbl.push_back(v(1, 16'h0080, M7, 0, 1, 0, C17, 0, 1, 16'h0080));
    tbl.push_back(v(1, 16'h0080, M7, 0, 0, 0, C17, 0, 0, 16'h0000));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].irq, tbl[i].mie, tbl[i].stall, tbl[i].mret);
      chk_all($sformatf("tbl%0d", i), tbl[i].trap, tbl[i].mcause, tbl[i].busy,
              tbl[i].ret, tbl[i].ack);
    end

    // Masked source stays pending, then fires once mie enables it.
    step(1, 16'h0000, 32'h0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 16'h0002, 32'h0, 0, 0);
      chk("masked.trap", {31'd0, trap_o}, 32'd0);
    end
    seen = 0;
    for (int i = 0; i < 2 && !seen; i++) begin
      step(1, 16'h0002, 32'h0002_0000, 0, 0);
      seen = trap_o;
    end
    chk("unmask.trap_seen", {31'd0, seen}, 32'd1);
    chk("unmask.mcause", mcause_o, C11);
    step(1, 16'h0002, 32'h0002_0000, 0, 0);
    chk_all("unmask.after", 0, C11, 1, 0, 16'h0);
    step(1, 16'h0002, 32'h0002_0000, 0, 1);
    chk_all("unmask.ret", 0, C11, 0, 1, 16'h0002);
    step(1, 16'h0002, 32'h0002_0000, 0, 0);

    // Stall blocks trap entry only while idle.
    step(1, 16'h0000, 32'h0002_0000, 1, 0);
    step(1, 16'h0002, 32'h0002_0000, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 16'h0002, 32'h0002_0000, 1, 0);
      chk("stall.trap", {31'd0, trap_o}, 32'd0);
    end
    step(1, 16'h0002, 32'h0002_0000, 0, 0);
    chk_all("stall.release", 1, C11, 0, 0, 16'h0);
    step(1, 16'h0002, 32'h0002_0000, 1, 0);
    chk_all("stall.in_trap", 0, C11, 1, 0, 16'h0);
    step(1, 16'h0002, 32'h0002_0000, 1, 1);
    chk_all("stall.ret", 0, C11, 0, 1, 16'h0002);
    step(1, 16'h0002, 32'h0002_0000, 0, 0);

    // Reset in the handler abandons service; a held line re-triggers once.
    step(1, 16'h0000, 32'h0001_0000, 0, 0);
    step(1, 16'h0001, 32'h0001_0000, 0, 0);
    step(1, 16'h0001, 32'h0001_0000, 0, 0);
    chk_all("rsth.trap", 1, C10, 0, 0, 16'h0);
    step(1, 16'h0001, 32'h0001_0000, 0, 0);
    step(0, 16'h0001, 32'h0001_0000, 0, 1);
    chk_all("rsth.in_reset", 0, 32'h0, 0, 0, 16'h0);
    step(0, 16'h0001, 32'h0001_0000, 0, 0);
    chk_all("rsth.in_reset2", 0, 32'h0, 0, 0, 16'h0);
    step(1, 16'h0001, 32'h0001_0000, 0, 0);
    chk_all("rsth.release", 0, 32'h0, 0, 0, 16'h0);
    step(1, 16'h0001, 32'h0001_0000, 0, 0);
    chk_all("rsth.retrap", 1, C10, 0, 0, 16'h0);
    step(1, 16'h0001, 32'h0001_0000, 0, 1);
    step(1, 16'h0001, 32'h0001_0000, 0, 1);
    chk_all("rsth.ret", 0, C10, 0, 1, 16'h0001);
    for (int i = 0; i < 6; i++) begin
      step(1, 16'h0001, 32'h0001_0000, 0, 0);
      chk("rsth.no_second", {31'd0, trap_o}, 32'd0);
    end

    // Randomized traffic against the reference model.
    step(0, '0, 32'h0, 0, 0);
    model_reset();
    rirq = '0;
    rmie = 32'hFFFF_0000;
    for (int c = 0; c < 3000; c++) begin
      rirq = rirq ^ (N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(0, 15) == 0) rmie = {$urandom_range(0, 65535), 16'h0000} | 32'(($urandom) & 32'hFFFF);
      rs    = ($urandom_range(0, 3) == 0);
      rm    = ($urandom_range(0, 2) == 0);
      rst_r = ($urandom_range(0, 79) != 0);
      model_step(rst_r, rirq, rmie, rs, rm);
      step(rst_r, rirq, rmie, rs, rm);
      chk_all("rand", m_trap, m_cause, m_hand, m_ret, m_ret ? 16'(1 << m_id) : 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt sequencer that sits between the platform interrupt lines and csr_controller.
- Latches rising-edge interrupt requests, masks them with mie, and picks the highest-priority source.
- Issues the one-cycle trap strobe and mcause value that csr_controller consumes, then tracks handler occupancy until mret.
- No nesting: one interrupt in service at a time; further requests stay pending.

Parameters:
- N_IRQ, 16, number of interrupt sources (1..16); source k maps to mie bit 16+k and cause code 16+k.

Ports:
- clk_i  input  1  system clock, all state on rising edge
- rst_i  input  1  synchronous, active-low reset
- irq_req_i  input  N_IRQ  interrupt request lines, level; rising edge creates a pending request
- mie_i  input  32  mie register value from csr_controller (mie_o)
- stall_i  input  1  core not at an instruction boundary; blocks trap entry
- mret_i  input  1  one-cycle pulse, core retiring mret
- trap_o  output  1  one-cycle trap strobe to csr_controller trap_i
- mcause_o  output  32  cause for csr_controller mcause_i
- busy_o  output  1  handler in service
- irq_ret_o  output  1  one-cycle pulse on handler return
- irq_ack_o  output  N_IRQ  one-hot, one-cycle acknowledge to the serviced source on return

Behaviour:
- Reset (rst_i==0 at clock edge): state=IDLE, pending=0, req_q=0, id=0.
- Reset output values: trap_o=0, mcause_o=0, busy_o=0, irq_ret_o=0, irq_ack_o=0.
- Reset mid-handler abandons service; no ack or ret is emitted.
- req_q resets to 0, so a line held high through reset release registers one new edge.
- Edge detect: req_q <= irq_req_i each cycle. edge = irq_req_i & ~req_q. pending[k] is set by edge[k].
- pending[k] clears only in TRAP for the selected id.
- If set and clear hit the same bit in the same cycle, set wins and the bit stays pending.
- Candidate vector: cand = pending & mie_i[16+N_IRQ-1:16].
- Selection: lowest index wins (index 0 is highest priority). Selection is combinational; id is registered on IDLE->TRAP.
- Masked pending bits are retained and are taken later if mie is enabled.
- FSM states: IDLE, TRAP, HANDLER, RETURN.
  - IDLE: if cand!=0 and stall_i==0, latch id and go to TRAP; otherwise stay.
  - TRAP: one cycle only. trap_o=1, pending[id] cleared, mcause_o register loaded with 32'h8000_0000 | (16+id). Next state HANDLER.
  - HANDLER: busy_o=1. mret_i goes to RETURN. New edges keep accumulating in pending.
  - RETURN: one cycle. irq_ret_o=1, irq_ack_o[id]=1, busy_o=0. Next state IDLE.
- mcause_o is a register: it changes only in the TRAP cycle and is held otherwise, including after return.
- mret_i is ignored in IDLE, TRAP and RETURN.
- stall_i is sampled only in IDLE. Once in TRAP, the trap completes regardless of stall_i.
- Latency: edge registered at edge E0 -> IDLE->TRAP at E1 -> trap_o high for the cycle after E1. This is 2 clock edges from the first sampled high of irq_req_i.
- Minimum spacing between traps: TRAP, HANDLER (at least 1 cycle), RETURN, IDLE. Back-to-back pending sources are therefore separated by at least 4 cycles.
- Width rules: cause code is a 5-bit zero-extended value; bit 31 is forced to 1; bits 30:5 are 0.

Decomposition:
- Shared package irq_pkg:
  - state enum irq_state_t {IDLE, TRAP, HANDLER, RETURN}
  - MCAUSE_INT_BIT = 32'h8000_0000
  - IRQ_CAUSE_BASE = 16
  - MIE_IRQ_LSB = 16
- One sub-module irq_prio_enc (N_IRQ-bit lowest-index priority encoder; outputs valid and index) is the natural split.
- The FSM and pending register stay in irq_controller.

Test Plan:
- irq_req_i[3] rises, mie_i=32'h0008_0000, stall_i=0 -> trap_o pulses exactly 1 cycle, 2 edges later; mcause_o=32'h8000_0013; busy_o=1 next cycle.
- Sources 5 and 2 rise together, both enabled -> first trap has mcause 0x8000_0012. mret_i -> irq_ack_o=0x0004 and irq_ret_o for 1 cycle. Second trap has mcause 0x8000_0015 and ack 0x0020.
- irq_req_i[1] rises with mie bit 17 clear -> no trap for 20 cycles. Set mie bit 17 -> trap with mcause 0x8000_0011 two cycles later.
- Pending source present, stall_i=1 for 5 cycles -> trap_o stays 0. stall_i drops -> trap_o in the next cycle. mret_i pulsed in IDLE -> no irq_ret_o.
- rst_i=0 during HANDLER with irq_req_i[0] held high -> all outputs 0 and no ack. After release, the held line produces one trap with mcause 0x8000_0010.
- Source 7 re-rises during HANDLER for source 7 -> remains pending; after RETURN a second trap with mcause 0x8000_0017 follows.
